drive_owner_arbiter: RTL and testbench

- Round-robin arbiter that shares one multi-driven net among N_REQ drivers.
- At most one driver owns the net at any time.
- A programmable dead (turnaround) period separates consecutive owners, so two drivers never contend on the net.
- Sits beside each shared wand/tri net group; its grant vector gates the per-driver output enables.

---
 rtl/drive_owner_arbiter_if.sv | 24 ++
 rtl/drive_owner_arbiter.sv | 176 +++++++++++++++++
 tb/tb_drive_owner_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/drive_owner_arbiter_if.sv
// Ownership handshake between the shared-net drivers and drive_owner_arbiter.
// master = driver side (raises req, receives grant); slave = arbiter side.
interface drive_owner_arbiter_if #(
   parameter int N_REQ = 4
) ();
   localparam int IW = $clog2(N_REQ);

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] grant;
   logic [IW-1:0]    owner_id;
   logic             owner_valid;
   logic             bus_idle;
   logic             timeout;

   modport master (
      output req,
      input  grant, owner_id, owner_valid, bus_idle, timeout
   );

   modport slave (
      input  req,
      output grant, owner_id, owner_valid, bus_idle, timeout
   );
endinterface

// File: rtl/drive_owner_arbiter.sv
// Round-robin owner arbiter for a shared multi-driven net, with TURNAROUND dead cycles between owners.
// Latency: req sampled at edge t -> registered grant at t+1; handover leaves TURNAROUND zero-grant cycles.
// Backpressure: none, req is a held level; `DRIVE_ARB_WATCHDOG_EN bounds ownership to MAX_HOLD cycles.
module drive_owner_arbiter #(
   parameter int N_REQ      = 4,
   parameter int TURNAROUND = 1,
   parameter int MAX_HOLD   = 16
) (
   input logic                  clk,
   input logic                  rst_n,
   drive_owner_arbiter_if.slave bus
);
   localparam int         IW        = $clog2(N_REQ);
   localparam int         TI        = (TURNAROUND > 0) ? TURNAROUND - 1 : 0;
   localparam logic [1:0] TURN_INIT = 2'(TI);

   if (N_REQ < 2 || N_REQ > 16 || TURNAROUND < 0 || TURNAROUND > 3 || MAX_HOLD < 1) begin : g_param_check
      $error("drive_owner_arbiter: parameter out of range");
   end

   typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

   state_t           state, state_nxt;
   logic [IW-1:0]    rr_ptr, rr_nxt;
   logic [1:0]       turn_cnt, turn_nxt;
   logic [N_REQ-1:0] grant_q, grant_nxt;
   logic [IW-1:0]    owner_q, owner_nxt;
   logic             valid_q, valid_nxt;
   logic             owner_req;
   logic             release_now;
   logic             arb_en;
   logic [N_REQ-1:0] eligible;
   logic [IW:0]      pick;

`ifdef DRIVE_ARB_WATCHDOG_EN
   localparam int HW = $clog2(MAX_HOLD + 1);

   logic [HW-1:0]    hold_cnt, hold_nxt;
   logic [N_REQ-1:0] mask, mask_nxt;
   logic             timeout_q, timeout_nxt;
   logic             force_rel;
`endif

   // Returns {found, index}: first eligible bit at or above ptr, wrapping at N_REQ.
   function automatic logic [IW:0] rr_pick(input logic [N_REQ-1:0] elig, input logic [IW-1:0] ptr);
      logic [IW:0] res;
      int          idx;
      res = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         idx = int'(ptr) + i;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (elig[idx]) res = {1'b1, IW'(idx)};
      end
      return res;
   endfunction

   always_comb begin
      state_nxt   = state;
      rr_nxt      = rr_ptr;
      turn_nxt    = turn_cnt;
      grant_nxt   = grant_q;
      owner_nxt   = owner_q;
      release_now = 1'b0;
      arb_en      = 1'b0;
      owner_req   = bus.req[owner_q];
`ifdef DRIVE_ARB_WATCHDOG_EN
      hold_nxt    = hold_cnt;
      mask_nxt    = mask & bus.req;
      timeout_nxt = 1'b0;
      force_rel   = 1'b0;
`endif

      case (state)
         OWN: begin
`ifdef DRIVE_ARB_WATCHDOG_EN
            force_rel = owner_req && (hold_cnt == HW'(MAX_HOLD));
            if (!owner_req || force_rel) begin
               release_now = 1'b1;
               if (force_rel) begin
                  mask_nxt[owner_q] = 1'b1;
                  timeout_nxt       = 1'b1;
               end
            end else begin
               hold_nxt = hold_cnt + HW'(1);
            end
`else
            if (!owner_req) release_now = 1'b1;
`endif
         end
         TURN: begin
            if (turn_cnt == 2'd0) arb_en = 1'b1;
            else                  turn_nxt = turn_cnt - 2'd1;
         end
         default: arb_en = 1'b1;
      endcase

      if (release_now) begin
         rr_nxt    = (int'(owner_q) == N_REQ - 1) ? '0 : owner_q + IW'(1);
         grant_nxt = '0;
         owner_nxt = '0;
         if (TURNAROUND > 0) begin
            state_nxt = TURN;
            turn_nxt  = TURN_INIT;
         end else begin
            arb_en = 1'b1;
         end
      end

      // Arbitration sees the post-release pointer and mask so a same-edge handover is fair.
`ifdef DRIVE_ARB_WATCHDOG_EN
      eligible = bus.req & ~mask_nxt;
`else
      eligible = bus.req;
`endif
      pick = rr_pick(eligible, rr_nxt);

      if (arb_en) begin
         if (pick[IW]) begin
            state_nxt = OWN;
            grant_nxt = '0;
            grant_nxt[pick[IW-1:0]] = 1'b1;
            owner_nxt = pick[IW-1:0];
`ifdef DRIVE_ARB_WATCHDOG_EN
            hold_nxt  = HW'(1);
`endif
         end else begin
            state_nxt = IDLE;
            grant_nxt = '0;
            owner_nxt = '0;
         end
      end

      valid_nxt = |grant_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         turn_cnt <= '0;
         grant_q  <= '0;
         owner_q  <= '0;
         valid_q  <= 1'b0;
      end else begin
         state    <= state_nxt;
         rr_ptr   <= rr_nxt;
         turn_cnt <= turn_nxt;
         grant_q  <= grant_nxt;
         owner_q  <= owner_nxt;
         valid_q  <= valid_nxt;
      end
   end

`ifdef DRIVE_ARB_WATCHDOG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt  <= '0;
         mask      <= '0;
         timeout_q <= 1'b0;
      end else begin
         hold_cnt  <= hold_nxt;
         mask      <= mask_nxt;
         timeout_q <= timeout_nxt;
      end
   end

   assign bus.timeout = timeout_q;
`else
   assign bus.timeout = 1'b0;
`endif

   assign bus.grant       = grant_q;
   assign bus.owner_id    = owner_q;
   assign bus.owner_valid = valid_q;
   assign bus.bus_idle    = (state != OWN);
endmodule

// File: tb/tb_drive_owner_arbiter.sv
// Directed bench for drive_owner_arbiter: three instances cover TURNAROUND = 1, 0 and 2.
// Watchdog vectors are selected by `DRIVE_ARB_WATCHDOG_EN, matching the RTL build.
module tb_drive_owner_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   drive_owner_arbiter_if #(.N_REQ(4)) a1 ();
   drive_owner_arbiter_if #(.N_REQ(4)) a0 ();
   drive_owner_arbiter_if #(.N_REQ(4)) a2 ();

   drive_owner_arbiter #(.N_REQ(4), .TURNAROUND(1), .MAX_HOLD(16)) u_t1 (
      .clk(clk), .rst_n(rst_n), .bus(a1.slave));
   drive_owner_arbiter #(.N_REQ(4), .TURNAROUND(0), .MAX_HOLD(16)) u_t0 (
      .clk(clk), .rst_n(rst_n), .bus(a0.slave));
   drive_owner_arbiter #(.N_REQ(4), .TURNAROUND(2), .MAX_HOLD(16)) u_t2 (
      .clk(clk), .rst_n(rst_n), .bus(a2.slave));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      a1.req = '0;
      a0.req = '0;
      a2.req = '0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         check("onehot_t1", 32'($onehot0(a1.grant)), 32'd1);
         check("onehot_t0", 32'($onehot0(a0.grant)), 32'd1);
         check("onehot_t2", 32'($onehot0(a2.grant)), 32'd1);
      end
   end

   initial begin
      logic [3:0] exp;
      int         k;

      rst_n  = 1'b0;
      a1.req = '0;
      a0.req = '0;
      a2.req = '0;
      tick(2);
      check("rst_grant", a1.grant, 32'h0);
      check("rst_owner_id", a1.owner_id, 32'h0);
      check("rst_owner_valid", a1.owner_valid, 32'h0);
      check("rst_bus_idle", a1.bus_idle, 32'h1);
      check("rst_timeout", a1.timeout, 32'h0);
      rst_n = 1'b1;
      tick(1);

      // single request, one-cycle grant latency, release into idle
      a1.req = 4'b0100;
      tick(1);
      check("single_grant", a1.grant, 32'h4);
      check("single_owner_id", a1.owner_id, 32'h2);
      check("single_owner_valid", a1.owner_valid, 32'h1);
      check("single_bus_idle", a1.bus_idle, 32'h0);
      tick(6);
      check("single_hold", a1.grant, 32'h4);
      a1.req = 4'b0000;
      tick(1);
      check("single_release_grant", a1.grant, 32'h0);
      check("single_release_idle", a1.bus_idle, 32'h1);
      check("single_release_id", a1.owner_id, 32'h0);
      check("single_release_valid", a1.owner_valid, 32'h0);
      tick(2);
      check("single_stays_idle", a1.grant, 32'h0);

      // round-robin wrap with one dead cycle between owners
      do_reset();
      a1.req = 4'b1111;
      tick(1);
      for (int i = 0; i < 5; i++) begin
         k   = i % 4;
         exp = 4'b0001 << k;
         check("rr_grant", a1.grant, 32'(exp));
         check("rr_owner_id", a1.owner_id, 32'(k));
         tick(2);
         check("rr_hold", a1.grant, 32'(exp));
         a1.req[k] = 1'b0;
         tick(1);
         check("rr_dead_grant", a1.grant, 32'h0);
         check("rr_dead_idle", a1.bus_idle, 32'h1);
         if (i < 4) begin
            a1.req[k] = 1'b1;
            tick(1);
         end else begin
            a1.req = '0;
         end
      end
      tick(2);
      check("rr_end_idle", a1.grant, 32'h0);

      // zero turnaround: direct handover on the release edge
      do_reset();
      a0.req = 4'b0011;
      tick(1);
      check("t0_first", a0.grant, 32'h1);
      tick(2);
      a0.req = 4'b0010;
      tick(1);
      check("t0_handover", a0.grant, 32'h2);
      check("t0_handover_id", a0.owner_id, 32'h1);
      check("t0_handover_idle", a0.bus_idle, 32'h0);
      a0.req = 4'b0000;
      tick(1);
      check("t0_to_idle", a0.grant, 32'h0);
      check("t0_to_idle_busidle", a0.bus_idle, 32'h1);

      // TURNAROUND=2, owner 3 drops as req[1] rises
      do_reset();
      a2.req = 4'b1000;
      tick(1);
      check("t2_owner3", a2.grant, 32'h8);
      tick(1);
      a2.req = 4'b0010;
      tick(1);
      check("t2_dead1", a2.grant, 32'h0);
      check("t2_dead1_idle", a2.bus_idle, 32'h1);
      tick(1);
      check("t2_dead2", a2.grant, 32'h0);
      tick(1);
      check("t2_new_owner", a2.grant, 32'h2);
      check("t2_new_id", a2.owner_id, 32'h1);

      // same event with req[0] also high: wrapped pointer favours 0
      do_reset();
      a2.req = 4'b1000;
      tick(2);
      a2.req = 4'b0011;
      tick(1);
      check("t2b_dead1", a2.grant, 32'h0);
      tick(1);
      check("t2b_dead2", a2.grant, 32'h0);
      tick(1);
      check("t2b_new_owner", a2.grant, 32'h1);

      // async reset while owner 3 holds the net
      do_reset();
      a1.req = 4'b1000;
      tick(1);
      check("ar_owner3", a1.grant, 32'h8);
      tick(1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_grant_now", a1.grant, 32'h0);
      check("ar_valid_now", a1.owner_valid, 32'h0);
      check("ar_busidle_now", a1.bus_idle, 32'h1);
      a1.req = 4'b1001;
      tick(1);
      rst_n = 1'b1;
      tick(1);
      check("ar_after_grant", a1.grant, 32'h1);
      check("ar_after_id", a1.owner_id, 32'h0);
      a1.req = 4'b0000;
      tick(2);

`ifdef DRIVE_ARB_WATCHDOG_EN
      // forced release after 16 owned cycles, requester 2 masked until it drops
      do_reset();
      a1.req = 4'b0101;
      tick(1);
      check("wd_first", a1.grant, 32'h1);
      a1.req = 4'b0100;
      tick(1);
      tick(1);
      check("wd_grant2", a1.grant, 32'h4);
      tick(15);
      check("wd_still_owned", a1.grant, 32'h4);
      check("wd_no_timeout_yet", a1.timeout, 32'h0);
      a1.req = 4'b0101;
      tick(1);
      check("wd_forced_grant", a1.grant, 32'h0);
      check("wd_timeout_pulse", a1.timeout, 32'h1);
      tick(1);
      check("wd_timeout_clear", a1.timeout, 32'h0);
      check("wd_other_served", a1.grant, 32'h1);
      tick(2);
      a1.req = 4'b0100;
      tick(1);
      check("wd_release0", a1.grant, 32'h0);
      tick(4);
      check("wd_masked", a1.grant, 32'h0);
      a1.req = 4'b0000;
      tick(1);
      a1.req = 4'b0100;
      tick(1);
      check("wd_unmasked", a1.grant, 32'h4);
      a1.req = 4'b0000;
      tick(3);
`else
      // without the watchdog ownership is unbounded and timeout never fires
      do_reset();
      a1.req = 4'b0101;
      tick(1);
      check("nowd_first", a1.grant, 32'h1);
      a1.req = 4'b0100;
      tick(2);
      check("nowd_grant2", a1.grant, 32'h4);
      tick(24);
      check("nowd_still_owned", a1.grant, 32'h4);
      check("nowd_timeout", a1.timeout, 32'h0);
      a1.req = 4'b0000;
      tick(3);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
